// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared FSM state codes and byte-packing constants for the register-bank dump reader
package dbg_pkg;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] REQ  = 3'd1;
   localparam logic [2:0] CAPT = 3'd2;
   localparam logic [2:0] SEND = 3'd3;
   localparam logic [2:0] CHK  = 3'd4;
   localparam logic [2:0] DONE = 3'd5;

   localparam int NB_BYTE        = 8;
   localparam int NB_DATA_DFLT   = 32;
   localparam int BYTES_PER_WORD = NB_DATA_DFLT / NB_BYTE;

   function automatic int bytes_per_word(input int nb_data, input int nb_byte);
      return nb_data / nb_byte;
   endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - loads one register word and hands it out LSB byte first over valid/ready
module word_byte_serializer #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_load,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_ready,
   output logic [NB_BYTE-1:0] o_byte,
   output logic               o_valid,
   output logic               o_accept,
   output logic               o_last_byte
);
   import dbg_pkg::*;

   localparam int BPW    = bytes_per_word(NB_DATA, NB_BYTE);
   localparam int NB_CNT = $clog2(BPW + 1);

   logic [NB_DATA-1:0] shift_q, shift_d;
   logic [NB_CNT-1:0]  cnt_q, cnt_d;
   logic               valid_q, valid_d;

   assign o_byte      = shift_q[NB_BYTE-1:0];
   assign o_valid     = valid_q;
   assign o_accept    = valid_q && i_ready;
   assign o_last_byte = (cnt_q == NB_CNT'(BPW - 1));

   // valid drops only after the final byte of the word has been taken
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (i_load) begin
         shift_d = i_data;
         cnt_d   = '0;
         valid_d = 1'b1;
      end else if (o_accept) begin
         shift_d = shift_q >> NB_BYTE;
         cnt_d   = cnt_q + NB_CNT'(1);
         if (o_last_byte) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/rb_dump_reader.sv
// rtl/rb_dump_reader.sv - walks the register bank debug port and streams every word to UART TX (RB_DUMP_CHECKSUM_EN adds a trailing XOR byte)
module rb_dump_reader #(
   parameter int NB_DATA  = 32,
   parameter int NB_REG   = 5,
   parameter int NUM_REGS = 32,
   parameter int NB_BYTE  = 8
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_start,
   output logic               o_rb_read_enable,
   output logic [NB_REG-1:0]  o_rb_read_address,
   input  logic [NB_DATA-1:0] i_rb_data,
   output logic [NB_BYTE-1:0] o_byte,
   output logic               o_byte_valid,
   input  logic               i_byte_ready,
   output logic               o_busy,
   output logic               o_done
);
   import dbg_pkg::*;

   logic [2:0]         state_q, state_d;
   logic [NB_REG-1:0]  index_q, index_d;
   logic               ser_load;
   logic               ser_valid;
   logic               ser_accept;
   logic               ser_last;
   logic [NB_BYTE-1:0] ser_byte;
   logic               word_done;
`ifdef RB_DUMP_CHECKSUM_EN
   logic [NB_BYTE-1:0] chk_q, chk_d;
`endif

   word_byte_serializer #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_ser (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_load      (ser_load),
      .i_data      (i_rb_data),
      .i_ready     (i_byte_ready),
      .o_byte      (ser_byte),
      .o_valid     (ser_valid),
      .o_accept    (ser_accept),
      .o_last_byte (ser_last)
   );

   assign word_done = ser_accept && ser_last;

   // index only advances on the way back to REQ, so it never wraps past NUM_REGS-1
   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      ser_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = REQ;
               index_d = '0;
            end
         end
         REQ: begin
            state_d = CAPT;
         end
         CAPT: begin
            ser_load = 1'b1;
            state_d  = SEND;
         end
         SEND: begin
            if (word_done) begin
               if (index_q != NB_REG'(NUM_REGS - 1)) begin
                  index_d = index_q + NB_REG'(1);
                  state_d = REQ;
               end else begin
`ifdef RB_DUMP_CHECKSUM_EN
                  state_d = CHK;
`else
                  state_d = DONE;
`endif
               end
            end
         end
`ifdef RB_DUMP_CHECKSUM_EN
         CHK: begin
            if (i_byte_ready) begin
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef RB_DUMP_CHECKSUM_EN
   always_comb begin
      chk_d = chk_q;
      if (state_q == IDLE && i_start) begin
         chk_d = '0;
      end else if (ser_accept) begin
         chk_d = chk_q ^ ser_byte;
      end
   end
`endif

   // byte lane is forced to zero whenever nothing is being offered
   always_comb begin
      o_byte_valid = ser_valid;
      o_byte       = ser_valid ? ser_byte : '0;
`ifdef RB_DUMP_CHECKSUM_EN
      if (state_q == CHK) begin
         o_byte_valid = 1'b1;
         o_byte       = chk_q;
      end
`endif
   end

   assign o_rb_read_enable  = (state_q == REQ);
   assign o_rb_read_address = index_q;
   assign o_busy            = (state_q != IDLE);
   assign o_done            = (state_q == DONE);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
      end
   end

`ifdef RB_DUMP_CHECKSUM_EN
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         chk_q <= '0;
      end else begin
         chk_q <= chk_d;
      end
   end
`endif

endmodule

// File: tb/tb_rb_dump_reader.sv
// tb/tb_rb_dump_reader.sv - randomized self-checking bench for rb_dump_reader against a byte-stream reference model
module tb_rb_dump_reader;

   localparam int NB_DATA  = 32;
   localparam int NB_REG   = 5;
   localparam int NUM_REGS = 32;
   localparam int NB_BYTE  = 8;
   localparam int BPW      = NB_DATA / NB_BYTE;
`ifdef RB_DUMP_CHECKSUM_EN
   localparam int EXTRA    = 1;
`else
   localparam int EXTRA    = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic ready = 1'b0;
   logic start1 = 1'b0;
   logic ready1 = 1'b1;

   logic               rd_en, rd_en1;
   logic [NB_REG-1:0]  rd_addr, rd_addr1;
   logic [NB_DATA-1:0] rb_data = '0;
   logic [NB_DATA-1:0] rb_data1 = '0;
   logic [NB_BYTE-1:0] obyte, obyte1;
   logic               ovalid, ovalid1, busy, busy1, done, done1;

   logic [NB_DATA-1:0] bank [NUM_REGS];

   int checks = 0;
   int fails  = 0;

   rb_dump_reader #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NUM_REGS(NUM_REGS), .NB_BYTE(NB_BYTE)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
      .o_rb_read_enable(rd_en), .o_rb_read_address(rd_addr), .i_rb_data(rb_data),
      .o_byte(obyte), .o_byte_valid(ovalid), .i_byte_ready(ready),
      .o_busy(busy), .o_done(done)
   );

   rb_dump_reader #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NUM_REGS(1), .NB_BYTE(NB_BYTE)) dut1 (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start1),
      .o_rb_read_enable(rd_en1), .o_rb_read_address(rd_addr1), .i_rb_data(rb_data1),
      .o_byte(obyte1), .o_byte_valid(ovalid1), .i_byte_ready(ready1),
      .o_busy(busy1), .o_done(done1)
   );

   // register bank: one-cycle read latency
   always @(posedge clk) begin
      if (rd_en)  rb_data  <= bank[rd_addr];
      if (rd_en1) rb_data1 <= bank[rd_addr1];
   end

   int                cyc = 0;
   logic [7:0]        bytes [$];
   logic [7:0]        bytes1 [$];
   logic [NB_REG-1:0] strobes [$];
   logic [NB_REG-1:0] strobes1 [$];
   int                strobe_cyc [$];
   int                done_cnt = 0, done_cyc = 0, done_run = 0, done_run_max = 0, stab_err = 0;
   int                done1_cnt = 0;
   logic              prev_hold = 1'b0;
   logic [7:0]        prev_byte = '0;
   logic [7:0]        exp_q [$];

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_hold = 1'b0;
         done_run  = 0;
      end else begin
         if (prev_hold && (ovalid !== 1'b1 || obyte !== prev_byte)) stab_err++;
         prev_hold = ovalid && !ready;
         prev_byte = obyte;
         if (ovalid && ready) bytes.push_back(obyte);
         if (rd_en) begin
            strobes.push_back(rd_addr);
            strobe_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_run++;
            if (done_run > done_run_max) done_run_max = done_run;
         end else begin
            done_run = 0;
         end
         if (ovalid1 && ready1) bytes1.push_back(obyte1);
         if (rd_en1) strobes1.push_back(rd_addr1);
         if (done1) done1_cnt++;
      end
   end

   task automatic clear_mon();
      bytes.delete();
      bytes1.delete();
      strobes.delete();
      strobes1.delete();
      strobe_cyc.delete();
      done_cnt = 0;
      done1_cnt = 0;
      done_run_max = 0;
      stab_err = 0;
   endtask

   // reference stream: each word LSB byte first, optional XOR of all data bytes at the end
   function automatic void fill_exp(input int n);
      logic [7:0] x;
      x = '0;
      exp_q.delete();
      for (int r = 0; r < n; r++) begin
         for (int b = 0; b < BPW; b++) begin
            exp_q.push_back(8'((bank[r] >> (8 * b)) & 32'hFF));
            x = x ^ 8'((bank[r] >> (8 * b)) & 32'hFF);
         end
      end
      if (EXTRA == 1) exp_q.push_back(x);
   endfunction

   function automatic int first_diff(input bit sel);
      int n;
      n = sel ? bytes1.size() : bytes.size();
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         if ((sel ? bytes1[i] : bytes[i]) !== exp_q[i]) return i;
      end
      if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
      return -1;
   endfunction

   task automatic run_dump(input bit rnd, input int pulse_at, input int budget, output bit to);
      int d0;
      d0 = done_cnt;
      to = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < budget; i++) begin
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start = (pulse_at >= 0 && bytes.size() == pulse_at);
         @(posedge clk); #1;
         if (done_cnt > d0) begin
            to = 1'b0;
            break;
         end
      end
      start = 1'b0;
      ready = 1'b1;
   endtask

   task automatic test_reset();
      int k;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rd_en, rd_addr, obyte, ovalid, busy, done} !== '0)
         begin fails++; $display("FAIL reset_outputs got %h exp 0", {rd_en, rd_addr, obyte, ovalid, busy, done}); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle busy got %b exp 0", busy); end

      for (int r = 0; r < NUM_REGS; r++) bank[r] = $urandom;
      clear_mon();
      ready = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (ovalid !== 1'b1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (ovalid !== 1'b1) begin fails++; $display("FAIL reset_reach_send valid got %b exp 1", ovalid); end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rd_en, rd_addr, obyte, ovalid, busy, done} !== '0)
         begin fails++; $display("FAIL reset_midsend got %h exp 0", {rd_en, rd_addr, obyte, ovalid, busy, done}); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done_cnt != 0 || bytes.size() != 0)
         begin fails++; $display("FAIL reset_abort busy %b done %0d bytes %0d exp 0 0 0", busy, done_cnt, bytes.size()); end
   endtask

   task automatic test_full_dump();
      bit to;
      int d, bad;
      for (int r = 0; r < NUM_REGS; r++) bank[r] = 32'hA0 + r;
      fill_exp(NUM_REGS);
      clear_mon();
      run_dump(1'b0, -1, 600, to);
      checks++;
      if (to) begin fails++; $display("FAIL full_timeout got timeout exp done"); end
      d = first_diff(1'b0);
      checks++;
      if (d != -1) begin fails++; $display("FAIL full_stream at byte %0d got %0d bytes exp %0d", d, bytes.size(), exp_q.size()); end
      bad = (strobes.size() != NUM_REGS);
      for (int i = 0; i < strobes.size(); i++) if (strobes[i] !== NB_REG'(i)) bad = 1;
      checks++;
      if (bad != 0) begin fails++; $display("FAIL full_strobes got %0d strobes exp %0d in order", strobes.size(), NUM_REGS); end
      checks++;
      if (done_cnt != 1 || done_run_max != 1)
         begin fails++; $display("FAIL full_done got cnt %0d len %0d exp 1 1", done_cnt, done_run_max); end
      checks++;
      if (strobe_cyc.size() == 0 || (done_cyc - strobe_cyc[0]) != NUM_REGS * (2 + BPW) + EXTRA)
         begin fails++; $display("FAIL full_latency got %0d exp %0d", strobe_cyc.size() ? done_cyc - strobe_cyc[0] : -1, NUM_REGS * (2 + BPW) + EXTRA); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL full_idle busy got %b exp 0", busy); end
   endtask

   task automatic test_backpressure();
      int hold, d, d0;
      bit to;
      for (int r = 0; r < NUM_REGS; r++) bank[r] = $urandom;
      bank[5] = 32'h11223344;
      fill_exp(NUM_REGS);
      clear_mon();
      hold = 0;
      to = 1'b1;
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (bytes.size() == 5 * BPW + 2 && hold < 10) begin
            ready = 1'b0;
            hold++;
            @(negedge clk);
            checks++;
            if (obyte !== 8'h22 || ovalid !== 1'b1)
               begin fails++; $display("FAIL bp_hold cycle %0d got %h/%b exp 22/1", hold, obyte, ovalid); end
            @(posedge clk); #1;
         end else begin
            ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         if (done_cnt > d0) begin
            to = 1'b0;
            break;
         end
      end
      ready = 1'b1;
      checks++;
      if (to || hold != 10) begin fails++; $display("FAIL bp_progress got timeout %b hold %0d exp 0 10", to, hold); end
      d = first_diff(1'b0);
      checks++;
      if (d != -1) begin fails++; $display("FAIL bp_stream at byte %0d got %0d bytes exp %0d", d, bytes.size(), exp_q.size()); end
      checks++;
      if (stab_err != 0) begin fails++; $display("FAIL bp_stable got %0d violations exp 0", stab_err); end
   endtask

   task automatic test_start_busy();
      bit to;
      int d, d0, n;
      for (int r = 0; r < NUM_REGS; r++) bank[r] = $urandom;
      fill_exp(NUM_REGS);
      clear_mon();
      run_dump(1'b0, 40, 600, to);
      checks++;
      if (to || done_cnt != 1 || strobes.size() != NUM_REGS)
         begin fails++; $display("FAIL busy_pulse got to %b done %0d strobes %0d exp 0 1 %0d", to, done_cnt, strobes.size(), NUM_REGS); end
      d = first_diff(1'b0);
      checks++;
      if (d != -1) begin fails++; $display("FAIL busy_stream at byte %0d got %0d bytes exp %0d", d, bytes.size(), exp_q.size()); end

      clear_mon();
      start = 1'b1;
      to = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         if (done_cnt > 0) begin
            to = 1'b0;
            break;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (to || strobes.size() != NUM_REGS + 1 || strobes[strobes.size() - 1] !== '0)
         begin fails++; $display("FAIL busy_restart got to %b strobes %0d exp 0 %0d last addr 0", to, strobes.size(), NUM_REGS + 1); end
      d0 = done_cnt;
      to = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         if (done_cnt > d0) begin
            to = 1'b0;
            break;
         end
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) exp_q.push_back(exp_q[i]);
      d = first_diff(1'b0);
      checks++;
      if (to || d != -1) begin fails++; $display("FAIL busy_second_dump at byte %0d timeout %b got %0d bytes exp %0d", d, to, bytes.size(), exp_q.size()); end
   endtask

   task automatic test_single_reg();
      bit to;
      int d;
      bank[0] = $urandom;
      fill_exp(1);
      clear_mon();
      @(posedge clk); #1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (done1_cnt > 0) begin
            to = 1'b0;
            break;
         end
      end
      checks++;
      if (to || done1_cnt != 1) begin fails++; $display("FAIL single_done got to %b done %0d exp 0 1", to, done1_cnt); end
      checks++;
      if (strobes1.size() != 1 || strobes1[0] !== '0)
         begin fails++; $display("FAIL single_strobe got %0d strobes exp 1 at addr 0", strobes1.size()); end
      d = first_diff(1'b1);
      checks++;
      if (d != -1) begin fails++; $display("FAIL single_stream at byte %0d got %0d bytes exp %0d", d, bytes1.size(), exp_q.size()); end
   endtask

`ifdef RB_DUMP_CHECKSUM_EN
   task automatic test_checksum();
      bit to;
      for (int r = 0; r < NUM_REGS; r++) bank[r] = 32'hFFFFFFFF;
      bank[0] = 32'h0;
      clear_mon();
      run_dump(1'b1, -1, 3000, to);
      checks++;
      if (to || bytes.size() != NUM_REGS * BPW + 1 || bytes[bytes.size() - 1] !== 8'h00)
         begin fails++; $display("FAIL chk_zero got %0d bytes last %h exp %0d 00", bytes.size(), bytes.size() ? bytes[bytes.size() - 1] : 8'hxx, NUM_REGS * BPW + 1); end
      bank[1] = 32'h000000FF;
      clear_mon();
      run_dump(1'b1, -1, 3000, to);
      checks++;
      if (to || bytes.size() != NUM_REGS * BPW + 1 || bytes[bytes.size() - 1] !== 8'hFF)
         begin fails++; $display("FAIL chk_ff got %0d bytes last %h exp %0d ff", bytes.size(), bytes.size() ? bytes[bytes.size() - 1] : 8'hxx, NUM_REGS * BPW + 1); end
   endtask
`endif

   initial begin
      for (int r = 0; r < NUM_REGS; r++) bank[r] = '0;
      test_reset();
      test_full_dump();
      test_backpressure();
      test_start_busy();
      test_single_reg();
`ifdef RB_DUMP_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
